bcd_frequency_synth: RTL and testbench

//  Programmable square-wave source: the transmit end of the frequency-measurement path.

---
 rtl/bcd_frequency_synth.sv | 154 +++++++++++++++
 tb/tb_bcd_frequency_synth.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_frequency_synth.sv
// ---------------------------------------------------------------------------
// bcd_frequency_synth
//
// Programmable square-wave source. A 4-digit BCD frequency (0..9999 Hz) is
// validated, converted to binary and used as the step of a fractional phase
// accumulator. The accumulator toggles Fout exactly 2*F times every CLK_HZ
// clocks, so a 1 s gate on a frequency meter reads back the programmed value.
//
// Parameters
//   CLK_HZ  clock frequency in Hz (must be >= 2*9999 for the full range)
//   ACC_W   accumulator width (2^ACC_W must exceed CLK_HZ + 2*9999)
//
// Ports
//   Clk       in   1   system clock, all logic on posedge
//   Rst       in   1   synchronous reset, active-high
//   Load      in   1   one-cycle request to apply Bcd_In, accepted when idle
//   Bcd_In    in   16  BCD frequency, [15:12]=thousands .. [3:0]=units
//   Busy      out  1   conversion in progress, Load ignored while high
//   Err       out  1   last accepted Load contained a digit > 9
//   Freq_Bin  out  14  binary frequency currently generated
//   Fout      out  1   square-wave output, ~50% duty
// ---------------------------------------------------------------------------
module bcd_frequency_synth #(
    parameter int CLK_HZ = 100_000_000,
    parameter int ACC_W  = 27
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Bcd_In,
    output logic        Busy,
    output logic        Err,
    output logic [13:0] Freq_Bin,
    output logic        Fout
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CONV,
        APPLY
    } state_t;

    localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);

    state_t             state_q,  state_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [13:0]        bin_q,    bin_d;
    logic [1:0]         cnt_q,    cnt_d;
    logic               err_q,    err_d;
    logic [13:0]        freq_q,   freq_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic               fout_q,   fout_d;

    logic               any_bad;
    logic [ACC_W-1:0]   step;
    logic [ACC_W:0]     sum;

    assign any_bad = (shadow_q[15:12] > 4'd9) || (shadow_q[11:8] > 4'd9) ||
                     (shadow_q[7:4]   > 4'd9) || (shadow_q[3:0]  > 4'd9);

    // ---------------- control / BCD conversion ----------------
    always_comb begin : fsm_comb
        // NOTE: every _d takes its hold value first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d  = state_q;
        shadow_d = shadow_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        freq_d   = freq_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    shadow_d = Bcd_In;
                    err_d    = 1'b0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (any_bad) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    bin_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // MSD first: the shadow register shifts left one digit per cycle.
                bin_d    = (bin_q << 3) + (bin_q << 1) + {10'd0, shadow_q[15:12]};
                shadow_d = shadow_q << 4;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = APPLY;
            end
            APPLY: begin
                freq_d  = bin_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- fractional phase accumulator ----------------
    assign step = ACC_W'({freq_q, 1'b0});
    assign sum  = {1'b0, acc_q} + {1'b0, step};

    always_comb begin : gen_comb
        acc_d  = acc_q;
        fout_d = fout_q;
        // A zero frequency parks the generator; applying zero parks it at once
        // so Fout is low from the first cycle after APPLY.
        if ((state_q == APPLY && bin_q == '0) || freq_q == '0) begin
            acc_d  = '0;
            fout_d = 1'b0;
        end else if (sum >= {1'b0, CLK_LIM}) begin
            acc_d  = sum[ACC_W-1:0] - CLK_LIM;
            fout_d = ~fout_q;
        end else begin
            acc_d  = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (Rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            freq_q   <= '0;
            acc_q    <= '0;
            fout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            freq_q   <= freq_d;
            acc_q    <= acc_d;
            fout_q   <= fout_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign Err      = err_q;
    assign Freq_Bin = freq_q;
    assign Fout     = fout_q;

endmodule

// File: tb/tb_bcd_frequency_synth.sv
// ---------------------------------------------------------------------------
// tb_bcd_frequency_synth
//
// Main instance runs with CLK_HZ=1000 / ACC_W=11 and is compared every cycle
// against a behavioural model: a countdown for the conversion latency, plain
// decimal arithmetic for the BCD value, and an unbounded phase total whose
// integer quotient by CLK_HZ gives the toggle count (Fout is its parity).
// A second instance with CLK_HZ=20000 / ACC_W=16 covers the full-scale value
// and reset during a conversion.
// ---------------------------------------------------------------------------
module tb_bcd_frequency_synth;

    localparam int CLK  = 1000;
    localparam int CLK2 = 20000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1, Load = 1'b0;
    logic [15:0] Bcd_In = '0;
    logic        Busy, Err, Fout;
    logic [13:0] Freq_Bin;

    logic        Rst2 = 1'b1, Load2 = 1'b0;
    logic [15:0] Bcd2 = '0;
    logic        Busy2, Err2, Fout2;
    logic [13:0] Freq2;

    always #5 Clk = ~Clk;

    bcd_frequency_synth #(.CLK_HZ(CLK), .ACC_W(11)) dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Bcd_In(Bcd_In),
        .Busy(Busy), .Err(Err), .Freq_Bin(Freq_Bin), .Fout(Fout)
    );

    bcd_frequency_synth #(.CLK_HZ(CLK2), .ACC_W(16)) dut_big (
        .Clk(Clk), .Rst(Rst2), .Load(Load2), .Bcd_In(Bcd2),
        .Busy(Busy2), .Err(Err2), .Freq_Bin(Freq2), .Fout(Fout2)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int     m_f = 0;          // frequency being generated
    int     m_left = 0;       // edges until the pending request resolves
    int     m_pend_val = 0;
    bit     m_pend_ok = 1'b0;
    bit     m_err = 1'b0;
    bit     m_apply;
    longint m_phase = 0;      // sum of 2F since the generator last parked

    always @(posedge Clk) begin
        if (Rst) begin
            m_f = 0; m_left = 0; m_err = 1'b0; m_phase = 0; m_pend_ok = 1'b0;
        end else begin
            m_apply = (m_left == 1) && m_pend_ok;
            if ((m_apply && m_pend_val == 0) || m_f == 0) m_phase = 0;
            else m_phase = m_phase + 2 * m_f;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend_ok) m_f = m_pend_val;
                    else m_err = 1'b1;
                end
            end else if (Load) begin
                m_pend_ok  = 1'b1;
                m_pend_val = 0;
                for (int k = 3; k >= 0; k--) begin
                    int d;
                    d = int'((Bcd_In >> (4 * k)) & 16'hF);
                    if (d > 9) m_pend_ok = 1'b0;
                    m_pend_val = m_pend_val * 10 + d;
                end
                m_err  = 1'b0;
                m_left = m_pend_ok ? 6 : 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("busy", 32'(Busy), 32'(m_left > 0));
            check("err", 32'(Err), 32'(m_err));
            check("freq", 32'(Freq_Bin), 32'(m_f));
            check("fout", 32'(Fout), 32'((m_phase / CLK) % 2));
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drives a one-cycle Load; returns at the negedge just after the sampling edge (edge 0).
    task automatic do_load(input bit big, input logic [15:0] v);
        @(negedge Clk);
        if (big) begin Load2 = 1'b1; Bcd2 = v; end
        else begin Load = 1'b1; Bcd_In = v; end
        @(negedge Clk);
        Load = 1'b0; Load2 = 1'b0;
    endtask

    task automatic wait_idle(input bit big);
        int n;
        n = 0;
        while ((big ? Busy2 : Busy) !== 1'b0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 20) check("busy_timeout", 32'(big ? Busy2 : Busy), 32'd0);
    endtask

    task automatic measure(input bit big, input int cycles, output int tog, output int rises,
                           output int gmin, output int gmax);
        logic prev, cur;
        int   since;
        bit   seen;
        prev = big ? Fout2 : Fout;
        tog = 0; rises = 0; gmin = 1 << 30; gmax = 0; since = 0; seen = 1'b0;
        repeat (cycles) begin
            @(negedge Clk);
            cur = big ? Fout2 : Fout;
            since++;
            if (cur !== prev) begin
                tog++;
                if (cur) rises++;
                if (seen) begin
                    if (since < gmin) gmin = since;
                    if (since > gmax) gmax = since;
                end
                seen = 1'b1;
                since = 0;
            end
            prev = cur;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tog, rises, gmin, gmax;
        logic [15:0] b;

        repeat (3) @(negedge Clk);
        Rst = 1'b0; Rst2 = 1'b0;
        cmp_en = 1'b1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_err", 32'(Err), 32'd0);
        check("reset_freq", 32'(Freq_Bin), 32'd0);
        check("reset_fout", 32'(Fout), 32'd0);

        // 100 Hz: latency and 5-cycle toggle spacing
        do_load(1'b0, 16'h0100);
        repeat (5) @(negedge Clk);
        check("t1_busy_edge5", 32'(Busy), 32'd1);
        check("t1_freq_before", 32'(Freq_Bin), 32'd0);
        @(negedge Clk);
        check("t1_busy_edge6", 32'(Busy), 32'd0);
        check("t1_freq_edge6", 32'(Freq_Bin), 32'd100);
        measure(1'b0, 100, tog, rises, gmin, gmax);
        check("t1_toggles", 32'(tog), 32'd20);
        check("t1_gap_min", 32'(gmin), 32'd5);
        check("t1_gap_max", 32'(gmax), 32'd5);

        // invalid digit while 100 Hz runs
        do_load(1'b0, 16'h12A4);
        check("t3_busy_edge0", 32'(Busy), 32'd1);
        @(negedge Clk);
        check("t3_err", 32'(Err), 32'd1);
        check("t3_busy", 32'(Busy), 32'd0);
        check("t3_freq", 32'(Freq_Bin), 32'd100);
        measure(1'b0, 50, tog, rises, gmin, gmax);
        check("t3_toggles", 32'(tog), 32'd10);
        check("t3_gap", 32'(gmin == 5 && gmax == 5), 32'd1);

        // 3 Hz
        do_load(1'b0, 16'h0003);
        wait_idle(1'b0);
        check("t2_err_cleared", 32'(Err), 32'd0);
        measure(1'b0, 1000, tog, rises, gmin, gmax);
        check("t2_toggles", 32'(tog), 32'd6);
        check("t2_meter", 32'(rises), 32'd3);
        check("t2_gaps", 32'(gmin >= 166 && gmax <= 167), 32'd1);

        // second Load at edge 3 is dropped
        do_load(1'b0, 16'h0200);
        repeat (2) @(negedge Clk);
        Load = 1'b1; Bcd_In = 16'h0050;
        @(negedge Clk);
        Load = 1'b0;
        wait_idle(1'b0);
        check("t4_freq", 32'(Freq_Bin), 32'd200);
        repeat (4) @(negedge Clk);
        check("t4_still_idle", 32'(Busy), 32'd0);
        measure(1'b0, 100, tog, rises, gmin, gmax);
        check("t4_toggles", 32'(tog), 32'd40);
        check("t4_gaps", 32'(gmin == 2 && gmax == 3), 32'd1);

        // zero parks the output, then restart at 250 Hz
        do_load(1'b0, 16'h0000);
        repeat (6) @(negedge Clk);
        check("t5_freq0", 32'(Freq_Bin), 32'd0);
        check("t5_fout0", 32'(Fout), 32'd0);
        measure(1'b0, 20, tog, rises, gmin, gmax);
        check("t5_no_toggle", 32'(tog), 32'd0);
        do_load(1'b0, 16'h0250);
        repeat (6) @(negedge Clk);
        check("t5_freq250", 32'(Freq_Bin), 32'd250);
        check("t5_fout_a6", 32'(Fout), 32'd0);
        @(negedge Clk);
        check("t5_fout_a7", 32'(Fout), 32'd0);
        @(negedge Clk);
        check("t5_fout_a8", 32'(Fout), 32'd1);

        // randomized loads, invalid digits, resets, loads while busy
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                @(negedge Clk); Rst = 1'b1;
                @(negedge Clk); Rst = 1'b0;
            end else begin
                b = to_bcd(int'($urandom_range(0, 500)));
                if (r <= 2) b[4 * $urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                do_load(1'b0, b);
            end
            repeat ($urandom_range(0, 12)) @(negedge Clk);
        end
        wait_idle(1'b0);
        repeat (30) @(negedge Clk);
        cmp_en = 1'b0;

        // full scale on the fast-clock instance
        do_load(1'b1, 16'h9999);
        wait_idle(1'b1);
        check("t6_freq", 32'(Freq2), 32'd9999);
        measure(1'b1, 20000, tog, rises, gmin, gmax);
        check("t6_toggles", 32'(tog), 32'd19998);

        // reset at edge 4 of a conversion discards it
        do_load(1'b1, 16'h1234);
        repeat (3) @(negedge Clk);
        Rst2 = 1'b1;
        @(negedge Clk);
        Rst2 = 1'b0;
        check("t6_rst_busy", 32'(Busy2), 32'd0);
        check("t6_rst_err", 32'(Err2), 32'd0);
        check("t6_rst_freq", 32'(Freq2), 32'd0);
        check("t6_rst_fout", 32'(Fout2), 32'd0);
        repeat (10) @(negedge Clk);
        check("t6_discarded", 32'(Freq2), 32'd0);
        check("t6_quiet", 32'(Fout2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
